// File: rtl/ps2_uart_system_if.sv
// UART serial pair of the PS/2 bridge; the bridge owns the master side,
// the far-end terminal (or bench) the slave side.
interface ps2_uart_system_if;
  logic uart_rxd;
  logic uart_txd;

  modport master (input uart_rxd, output uart_txd);
  modport slave  (output uart_rxd, input uart_txd);
endinterface

// File: rtl/ps2_uart_system.sv
// PS/2 keyboard to UART bridge: valid scancodes are sent as 8N1 frames, UART
// receive bytes are echoed, and PS/2 bytes win the shared transmitter.
module ps2_uart_system #(
  parameter int unsigned clk_freq       = 50_000_000,
  parameter int unsigned uart_baud_rate = 115_200
) (
  input  logic              clk,
  input  logic              rst,
  output logic              led,
  inout  wire               ps2_clk,
  inout  wire               ps2_data,
  ps2_uart_system_if.master uart
);

  localparam int unsigned BIT_RAW  = clk_freq / uart_baud_rate;
  localparam int unsigned BIT_CYC  = (BIT_RAW < 2) ? 2 : BIT_RAW;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned TO_RAW   = clk_freq / 5000;
  localparam int unsigned TO_CYC   = (TO_RAW < 1) ? 1 : TO_RAW;
  localparam int unsigned CNT_W    = $clog2(BIT_CYC + 1);
  localparam int unsigned TO_W     = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [1:0] ps2c_sync, ps2d_sync;
  logic [2:0] rxd_sync;
  logic [7:0] ps2c_hist, ps2d_hist;
  logic       ps2c_filt, ps2d_filt, ps2c_filt_q;
  logic       ps2_fall_c, rxd, rxd_fall_c;

  // Pin synchronizers and 8-sample stability filters; the PS/2 lines are only read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps2c_sync   <= 2'b11;
      ps2d_sync   <= 2'b11;
      rxd_sync    <= 3'b111;
      ps2c_hist   <= '1;
      ps2d_hist   <= '1;
      ps2c_filt   <= 1'b1;
      ps2d_filt   <= 1'b1;
      ps2c_filt_q <= 1'b1;
    end else begin
      ps2c_sync   <= {ps2c_sync[0], ps2_clk};
      ps2d_sync   <= {ps2d_sync[0], ps2_data};
      rxd_sync    <= {rxd_sync[1:0], uart.uart_rxd};
      ps2c_hist   <= {ps2c_hist[6:0], ps2c_sync[1]};
      ps2d_hist   <= {ps2d_hist[6:0], ps2d_sync[1]};
      if (&ps2c_hist)       ps2c_filt <= 1'b1;
      else if (~|ps2c_hist) ps2c_filt <= 1'b0;
      if (&ps2d_hist)       ps2d_filt <= 1'b1;
      else if (~|ps2d_hist) ps2d_filt <= 1'b0;
      ps2c_filt_q <= ps2c_filt;
    end
  end

  assign ps2_fall_c = ps2c_filt_q & ~ps2c_filt;
  assign rxd        = rxd_sync[1];
  assign rxd_fall_c = rxd_sync[2] & ~rxd_sync[1];

  logic [3:0]      ps2_cnt;
  logic [9:0]      ps2_shift;
  logic [TO_W-1:0] ps2_idle;
  logic [10:0]     ps2_frame_c;
  logic            ps2_accept_c;
  logic [7:0]      ps2_byte, echo_byte;
  logic            ps2_valid, echo_valid;
  logic            load_ps2_c, load_echo_c, echo_load_c;

  // Bits arrive start-first, so after ten right shifts plus the stop bit the frame is in order.
  assign ps2_frame_c  = {ps2d_filt, ps2_shift};
  assign ps2_accept_c = ps2_fall_c && (ps2_cnt == 4'd10) && !ps2_frame_c[0]
                        && ps2_frame_c[10] && (^ps2_frame_c[9:1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps2_cnt   <= '0;
      ps2_shift <= '0;
      ps2_idle  <= '0;
      ps2_byte  <= '0;
      ps2_valid <= 1'b0;
      led       <= 1'b0;
    end else begin
      if (ps2_fall_c) begin
        ps2_shift <= {ps2d_filt, ps2_shift[9:1]};
        ps2_cnt   <= (ps2_cnt == 4'd10) ? 4'd0 : ps2_cnt + 4'd1;
        ps2_idle  <= '0;
      end else if (ps2_cnt != 4'd0) begin
        // A stalled keyboard must not leave stale bits in front of the next frame.
        if (ps2_idle == TO_W'(TO_CYC - 1)) begin
          ps2_cnt  <= '0;
          ps2_idle <= '0;
        end else begin
          ps2_idle <= ps2_idle + TO_W'(1);
        end
      end
      if (ps2_accept_c) begin
        ps2_byte  <= ps2_frame_c[8:1];
        ps2_valid <= 1'b1;
        led       <= ~led;
      end else if (load_ps2_c) begin
        ps2_valid <= 1'b0;
      end
    end
  end

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;

  // UART receiver: verify start at mid-bit, then sample data and stop one bit apart.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + CNT_W'(1);
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    echo_load_c = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rxd_fall_c) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == CNT_W'(HALF_CYC - 1)) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rxd ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == CNT_W'(BIT_CYC - 1)) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rxd, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == CNT_W'(BIT_CYC - 1)) begin
        rx_cnt_d    = '0;
        echo_load_c = rxd;
        rx_state_d  = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  tx_state_t        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_bit_end_c, tx_pick_c, txd_d;

  // Transmitter with arbiter; reloading at the end of STOP keeps frames back to back.
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q + CNT_W'(1);
    tx_bit_d     = tx_bit_q;
    tx_byte_d    = tx_byte_q;
    load_ps2_c   = 1'b0;
    load_echo_c  = 1'b0;
    tx_bit_end_c = (tx_cnt_q == CNT_W'(BIT_CYC - 1));
    tx_pick_c    = (tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_bit_end_c);
    unique case (tx_state_q)
      TX_IDLE:  tx_cnt_d = '0;
      TX_START: if (tx_bit_end_c) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_bit_end_c) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_bit_end_c) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_pick_c && (ps2_valid || echo_valid)) begin
      load_ps2_c  = ps2_valid;
      load_echo_c = !ps2_valid;
      tx_byte_d   = ps2_valid ? ps2_byte : echo_byte;
      tx_cnt_d    = '0;
      tx_state_d  = TX_START;
    end
    unique case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_byte_d[tx_bit_d];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      echo_byte     <= '0;
      echo_valid    <= 1'b0;
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_byte_q     <= '0;
      uart.uart_txd <= 1'b1;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_byte_q     <= tx_byte_d;
      uart.uart_txd <= txd_d;
      if (echo_load_c) begin
        echo_byte  <= rx_shift_q;
        echo_valid <= 1'b1;
      end else if (load_echo_c) begin
        echo_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_uart_system.sv
// Bench for ps2_uart_system: drives PS/2 and UART frames, decodes the UART
// transmit line and compares it against the expected byte stream.
module tb_ps2_uart_system;
  localparam int unsigned CLK_FREQ = 5_000_000;
  localparam int unsigned BAUD     = 50_000;
  localparam int BIT       = 100;          // clocks per UART bit at these settings
  localparam int FRAME     = 10 * BIT;
  localparam int FAST_HALF = 40;           // 16 us PS/2 bit, fits a frame inside one UART frame
  localparam int SLOW_HALF = 193;          // ~77 us PS/2 bit

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic led;
  logic ps2_clk_drv  = 1'b1;
  logic ps2_data_drv = 1'b1;
  wire  ps2_clk_w, ps2_data_w;
  assign ps2_clk_w  = ps2_clk_drv;
  assign ps2_data_w = ps2_data_drv;

  ps2_uart_system_if uart_if ();

  ps2_uart_system #(.clk_freq(CLK_FREQ), .uart_baud_rate(BAUD)) dut (
    .clk      (clk),
    .rst      (rst),
    .led      (led),
    .ps2_clk  (ps2_clk_w),
    .ps2_data (ps2_data_w),
    .uart     (uart_if)
  );

  always #100 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       framing_ok;
    int         start_cyc;
  } tx_frame_t;

  tx_frame_t tx_q[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic exp_led = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Decode every 8N1 frame on uart_txd by mid-bit sampling at the nominal baud.
  initial begin : tx_monitor
    logic prev;
    tx_frame_t f;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !uart_if.uart_txd) begin
        f.start_cyc = cyc;
        repeat (BIT / 2) @(negedge clk);
        f.framing_ok = !uart_if.uart_txd;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          f.data[i] = uart_if.uart_txd;
        end
        repeat (BIT) @(negedge clk);
        f.framing_ok = f.framing_ok & uart_if.uart_txd;
        tx_q.push_back(f);
      end
      prev = uart_if.uart_txd;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k;
    k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  task automatic ps2_send(input logic [7:0] data, input bit bad_par, input int half, input int nedges);
    logic [10:0] f;
    f = {1'b1, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      ps2_data_drv = f[i];
      wait_clks(half);
      ps2_clk_drv = 1'b0;
      wait_clks(half);
      ps2_clk_drv = 1'b1;
    end
    ps2_data_drv = 1'b1;
  endtask

  task automatic uart_send(input logic [7:0] data);
    uart_if.uart_rxd = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_if.uart_rxd = data[i];
      wait_clks(BIT);
    end
    uart_if.uart_rxd = 1'b1;
    wait_clks(BIT);
  endtask

  task automatic test_reset();
    uart_if.uart_rxd = 1'b1;
    ps2_clk_drv  = 1'b1;
    ps2_data_drv = 1'b1;
    #10 rst = 1'b0;
    #80;
    tests_run++;
    if (led !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_led: got %b expected 0", led);
    end
    tests_run++;
    if (uart_if.uart_txd !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_txd: got %b expected 1", uart_if.uart_txd);
    end
    wait_clks(4);
    rst = 1'b1;
    wait_clks(50);
    tests_run++;
    if (uart_if.uart_txd !== 1'b1 || led !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got txd=%b led=%b expected txd=1 led=0", uart_if.uart_txd, led);
    end
    tests_run++;
    if (tx_q.size() != 0) begin
      tests_failed++;
      $display("FAIL idle_no_frames: got %0d frames expected 0", tx_q.size());
    end
  endtask

  task automatic test_ps2_forward();
    tx_q.delete();
    ps2_send(8'h1C, 1'b0, SLOW_HALF, 11);
    exp_led = ~exp_led;
    wait_tx(1, 3 * FRAME);
    wait_clks(BIT);
    tests_run++;
    if (tx_q.size() != 1) begin
      tests_failed++;
      $display("FAIL ps2_fwd_count: got %0d frames expected 1", tx_q.size());
    end
    if (tx_q.size() > 0) begin
      tests_run++;
      if (tx_q[0].data !== 8'h1C || tx_q[0].framing_ok !== 1'b1) begin
        tests_failed++;
        $display("FAIL ps2_fwd_data: got %h framing=%b expected 1c framing=1", tx_q[0].data, tx_q[0].framing_ok);
      end
    end
    tests_run++;
    if (led !== exp_led) begin
      tests_failed++;
      $display("FAIL ps2_fwd_led: got %b expected %b", led, exp_led);
    end
  endtask

  task automatic test_bad_parity();
    tx_q.delete();
    ps2_send(8'h1C, 1'b1, FAST_HALF, 11);
    wait_clks(2 * FRAME);
    tests_run++;
    if (tx_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bad_parity_count: got %0d frames expected 0", tx_q.size());
    end
    tests_run++;
    if (led !== exp_led) begin
      tests_failed++;
      $display("FAIL bad_parity_led: got %b expected %b", led, exp_led);
    end
  endtask

  task automatic test_ps2_random();
    logic [7:0] d;
    bit bad;
    int n_exp;
    for (int it = 0; it < 5; it++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      tx_q.delete();
      ps2_send(d, bad, FAST_HALF, 11);
      n_exp = bad ? 0 : 1;
      if (!bad) exp_led = ~exp_led;
      if (bad) wait_clks(2 * FRAME);
      else wait_tx(1, 3 * FRAME);
      wait_clks(BIT);
      tests_run++;
      if (tx_q.size() != n_exp) begin
        tests_failed++;
        $display("FAIL ps2_rand_count: byte %h bad=%0d got %0d frames expected %0d", d, bad, tx_q.size(), n_exp);
      end
      if (n_exp == 1 && tx_q.size() > 0) begin
        tests_run++;
        if (tx_q[0].data !== d || tx_q[0].framing_ok !== 1'b1) begin
          tests_failed++;
          $display("FAIL ps2_rand_data: got %h framing=%b expected %h framing=1", tx_q[0].data, tx_q[0].framing_ok, d);
        end
      end
      tests_run++;
      if (led !== exp_led) begin
        tests_failed++;
        $display("FAIL ps2_rand_led: got %b expected %b", led, exp_led);
      end
    end
  endtask

  task automatic test_uart_echo();
    logic [7:0] d;
    for (int it = 0; it < 4; it++) begin
      d = (it == 0) ? 8'h41 : 8'($urandom);
      tx_q.delete();
      uart_send(d);
      wait_tx(1, 3 * FRAME);
      wait_clks(BIT);
      tests_run++;
      if (tx_q.size() != 1) begin
        tests_failed++;
        $display("FAIL echo_count: byte %h got %0d frames expected 1", d, tx_q.size());
      end
      if (tx_q.size() > 0) begin
        tests_run++;
        if (tx_q[0].data !== d || tx_q[0].framing_ok !== 1'b1) begin
          tests_failed++;
          $display("FAIL echo_data: got %h framing=%b expected %h framing=1", tx_q[0].data, tx_q[0].framing_ok, d);
        end
      end
      tests_run++;
      if (led !== exp_led) begin
        tests_failed++;
        $display("FAIL echo_led: got %b expected %b", led, exp_led);
      end
    end
  endtask

  // PS/2 byte A occupies the transmitter while 0x1C and echo 0x55 both become pending.
  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] exp_bytes [3];
    a = 8'($urandom);
    exp_bytes[0] = a;
    exp_bytes[1] = 8'h1C;
    exp_bytes[2] = 8'h55;
    tx_q.delete();
    fork
      begin
        ps2_send(a, 1'b0, FAST_HALF, 11);
        ps2_send(8'h1C, 1'b0, FAST_HALF, 11);
      end
      begin
        wait_clks(800);
        uart_send(8'h55);
      end
    join
    wait_tx(3, 4 * FRAME);
    wait_clks(BIT);
    tests_run++;
    if (tx_q.size() != 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d frames expected 3", tx_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < tx_q.size()) begin
        tests_run++;
        if (tx_q[i].data !== exp_bytes[i] || tx_q[i].framing_ok !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_order[%0d]: got %h framing=%b expected %h framing=1", i, tx_q[i].data, tx_q[i].framing_ok, exp_bytes[i]);
        end
      end
      if (i > 0 && i < tx_q.size()) begin
        tests_run++;
        if (tx_q[i].start_cyc - tx_q[i-1].start_cyc != FRAME) begin
          tests_failed++;
          $display("FAIL b2b_gap[%0d]: got %0d clocks between starts expected %0d", i, tx_q[i].start_cyc - tx_q[i-1].start_cyc, FRAME);
        end
      end
    end
    tests_run++;
    if (led !== exp_led) begin
      tests_failed++;
      $display("FAIL b2b_led: got %b expected %b", led, exp_led);
    end
  endtask

  task automatic test_timeout();
    tx_q.delete();
    ps2_send(8'($urandom), 1'b0, FAST_HALF, 5);
    wait_clks(1500);
    ps2_send(8'hF0, 1'b0, FAST_HALF, 11);
    exp_led = ~exp_led;
    wait_tx(1, 3 * FRAME);
    wait_clks(2 * FRAME);
    tests_run++;
    if (tx_q.size() != 1) begin
      tests_failed++;
      $display("FAIL timeout_count: got %0d frames expected 1", tx_q.size());
    end
    if (tx_q.size() > 0) begin
      tests_run++;
      if (tx_q[0].data !== 8'hF0 || tx_q[0].framing_ok !== 1'b1) begin
        tests_failed++;
        $display("FAIL timeout_data: got %h framing=%b expected f0 framing=1", tx_q[0].data, tx_q[0].framing_ok);
      end
    end
    tests_run++;
    if (led !== exp_led) begin
      tests_failed++;
      $display("FAIL timeout_led: got %b expected %b", led, exp_led);
    end
  endtask

  task automatic test_reset_mid_tx();
    if (exp_led == 1'b0) begin
      ps2_send(8'h5A, 1'b0, FAST_HALF, 11);
      exp_led = 1'b1;
      wait_clks(2 * FRAME);
    end
    tests_run++;
    if (led !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_led: got %b expected 1", led);
    end
    uart_send(8'h00);
    wait_clks(3 * BIT);
    tests_run++;
    if (uart_if.uart_txd !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_tx_low: got %b expected 0", uart_if.uart_txd);
    end
    @(negedge clk);
    #30 rst = 1'b0;
    #1;
    tests_run++;
    if (uart_if.uart_txd !== 1'b1 || led !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got txd=%b led=%b expected txd=1 led=0", uart_if.uart_txd, led);
    end
    wait_clks(5);
    rst = 1'b1;
    exp_led = 1'b0;
    wait_clks(2 * FRAME);
    tests_run++;
    if (uart_if.uart_txd !== 1'b1 || led !== exp_led) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got txd=%b led=%b expected txd=1 led=0", uart_if.uart_txd, led);
    end
  endtask

  initial begin
    test_reset();
    test_ps2_forward();
    test_bad_parity();
    test_ps2_random();
    test_uart_echo();
    test_back_to_back();
    test_timeout();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_uart_system.md
# ps2_uart_system

Top-level bridge: receives scancode bytes from a PS/2 keyboard and forwards each valid byte as an 8N1 frame on the UART transmit line. Bytes received on the UART receive line are echoed back on the same transmitter; PS/2 traffic has priority. A status LED toggles on every valid PS/2 byte. This is the board-level top of the PS/2 example design.

## Interface
- clk_freq, 50000000, system clock frequency in Hz.
- uart_baud_rate, 115200, UART bit rate; bit period = clk_freq / uart_baud_rate clocks, integer truncation, minimum 2.
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-low reset.
- led  output  1  toggles on each accepted PS/2 byte.
- ps2_clk  inout  1  PS/2 clock; the block never drives it (permanent high-Z), input use only.
- ps2_data  inout  1  PS/2 data; never driven (high-Z), input use only.
- uart_rxd  input  1  UART receive, idle high.
- uart_txd  output  1  UART transmit, idle high.

## Operation
- Reset: all state cleared; led=0, uart_txd=1, both holding registers empty, all FSMs idle.
- PS/2 input conditioning: ps2_clk and ps2_data each pass a 2-flop synchronizer, then an 8-sample stability filter; a filtered ps2_clk falling edge is the sample event.
- PS/2 frame: 11 bits sampled at falling edges: start (0), 8 data LSB first, odd parity, stop (1).
- Accept when start=0, parity odd over data+parity, stop=1; otherwise discard silently, no LED change.
- Inter-bit timeout: no filtered falling edge for clk_freq/5000 cycles (200 µs) while mid-frame -> bit counter reset, partial frame discarded.
- Accepted byte -> PS/2 holding register (valid flag set); led toggles. A new byte while full overwrites the register (newest wins).
- UART RX: falling edge on synchronized uart_rxd starts reception; re-check at half bit period (still low, else abort as glitch); sample 8 data bits at full bit periods, LSB first; stop bit must be 1, else discard. Accepted byte -> echo holding register (overwrite if full).
- TX arbiter: when transmitter idle, PS/2 register wins over echo register; loaded register's valid flag cleared on load.
- TX FSM states IDLE -> START -> DATA(8) -> STOP -> IDLE; each state held exactly one bit period; uart_txd = 0, data LSB first, 1.

## Timing
- Filter/synchronizer latency: 2 + 8 clocks from pin to filtered edge.
- Accepted PS/2 byte: led toggles and holding register loads 1 clock after stop-bit filtered edge.
- TX start bit begins within 2 clocks of a holding register becoming valid while TX idle.
- One UART frame = 10 bit periods; back-to-back frames with no extra idle bit.
- Simultaneous PS/2 and echo valid: PS/2 byte sent first, echo byte next.
- Reset asserted mid-frame: uart_txd returns to 1 asynchronously; partial frames lost; led=0.

## Test plan
- Reset: hold rst=0 80 ns -> led=0, uart_txd=1, ps2 lines never driven (remain Z/pulled).
- PS/2 frame 0x1C, parity 0, stop 1, 77 µs bit period -> uart_txd emits 0x1C (start 0, 0,0,1,1,1,0,0,0, stop 1) at configured baud; led=1.
- PS/2 frame with wrong parity -> no UART frame, led unchanged.
- UART rx 0x41 at configured baud -> same byte 0x41 echoed on uart_txd, led unchanged.
- PS/2 byte 0x1C accepted in the same clock as echo byte 0x55 -> 0x1C transmitted then 0x55, no gap.
- Partial PS/2 frame (5 edges) then 300 µs silence then full frame 0xF0 -> only 0xF0 forwarded; reset mid-TX -> uart_txd=1 immediately.
